xalu: RTL and testbench
=======================

// Module: xalu
// PURPOSE
//  E-stage multiply/divide unit with architectural HI/LO registers. Executes mult/multu/div/divu
//  as a multi-cycle operation, plus mthi/mtlo writes and mfhi/mflo reads. Its Busy output feeds the
//  pause (stall) unit, which holds any D-stage XALU instruction while Busy is high.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy stays high after a mult/multu start (>=1)
//  DIV_CYCLES   10  cycles Busy stays high after a div/divu start (>=1)
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   asynchronous reset, active-low
//  XALUOp_E  in   4   op in E: 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//  A         in   32  rs operand (forwarded)
//  B         in   32  rt operand (forwarded)
//  Start     out  1   comb: XALUOp_E in {1..4} and unit idle (and, if enabled, not cancelled)
//  Busy      out  1   comb: Start | (state==RUN)
//  HI        out  32  architectural HI
//  LO        out  32  architectural LO
//  XALUOut   out  32  comb: HI when op==7, LO when op==8, else 0
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, cnt=0, HI=LO=0, staging regs=0; Busy/Start follow to 0.
//  - FSM: IDLE --Start--> RUN; RUN --cnt==1--> IDLE (commit). No other transitions.
//  - Start edge: latch result into HI_n/LO_n; cnt <= MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
//  - RUN: cnt decrements each edge; on the edge where cnt==1: HI<=HI_n, LO<=LO_n, state<=IDLE.
//    Busy is high for exactly N+1 cycles: the Start cycle plus N RUN cycles.
//  - Arithmetic: mult = signed 32x32 -> 64, multu unsigned; {HI,LO} = product.
//    div/divu: LO = quotient (truncated toward zero), HI = remainder (sign follows dividend).
//    B==0 (div or divu): LO = 32'hFFFF_FFFF, HI = A. div 0x8000_0000 / -1: LO = 0x8000_0000, HI = 0.
//  - mthi/mtlo (5/6): write HI/LO with A on the edge, only in IDLE. mfhi/mflo (7/8) read
//    HI/LO combinationally. While in RUN, ops 1..8 in E are ignored; the pause unit guarantees none
//    arrive. HI/LO keep their old values until commit.
//  - A/B are only sampled on the Start edge; later changes have no effect.
//  - Op 0 or ops 9..15: no state change; XALUOut=0.
//  - Async reset mid-RUN: operation is discarded; HI/LO = 0.
// CONFIGURATION
//  XALU_CANCEL_EN defined: extra input Cancel (1 bit, comb from CP0 exception/interrupt in M).
//    Start is gated by !Cancel; mthi/mtlo writes are gated by !Cancel. Cancel during RUN is ignored,
//    and the in-flight op commits normally.
//  Undefined: no Cancel port; every op 1..6 in E while IDLE takes effect.
// TESTING
//  1. Reset low mid-RUN of div -> HI=LO=0, Busy=0 immediately; FSM returns to IDLE.
//  2. mult A=-3 (FFFF_FFFD), B=7 -> Busy high 6 cycles; then HI=FFFF_FFFF, LO=FFFF_FFEB.
//  3. divu A=100, B=7 -> Busy high 11 cycles; then LO=14, HI=2. HI/LO unchanged before commit.
//  4. div A=-7, B=2 -> LO=FFFF_FFFD, HI=FFFF_FFFF. div A=5, B=0 -> LO=FFFF_FFFF, HI=5.
//  5. mthi A=1234 then mflo/mfhi -> XALUOut=1234 on mfhi. mult issued again while RUN -> ignored.
//  6. XALU_CANCEL_EN: Cancel=1 with mult in E -> Start=0, Busy=0, HI/LO held; Cancel=1 in RUN -> commits.

Source files
------------

// File: rtl/xalu.sv
// rtl/xalu.sv - E-stage multi-cycle mult/div unit with architectural HI/LO registers
// Optional feature macro: XALU_CANCEL_EN (adds Cancel input gating starts and mthi/mtlo writes)
module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef XALU_CANCEL_EN
    input  logic        Cancel,
`endif
    input  logic [3:0]  XALUOp_E,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] XALUOut
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      hi_n_q, hi_n_d, lo_n_q, lo_n_d;
    logic             cancel;

`ifdef XALU_CANCEL_EN
    assign cancel = Cancel;
`else
    assign cancel = 1'b0;
`endif

    logic [63:0] prod_s, prod_u;
    logic [31:0] div_u_b, uq, ur;
    logic [31:0] abs_a, abs_b, sq_mag, sr_mag, sq, sr;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'd0, A} * {32'd0, B};
        // Divisor forced nonzero so the datapath never divides by zero; B==0 is overridden below.
        div_u_b = (B == 32'd0) ? 32'd1 : B;
        uq      = A / div_u_b;
        ur      = A % div_u_b;
        abs_a   = A[31] ? (32'd0 - A) : A;
        abs_b   = B[31] ? (32'd0 - B) : div_u_b;
        sq_mag  = abs_a / abs_b;
        sr_mag  = abs_a % abs_b;
        sq      = (A[31] ^ B[31]) ? (32'd0 - sq_mag) : sq_mag;
        sr      = A[31] ? (32'd0 - sr_mag) : sr_mag;
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        case (XALUOp_E)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV:   begin res_hi = sr; res_lo = sq; end
            OP_DIVU:  begin res_hi = ur; res_lo = uq; end
            default:  ;
        endcase
        if ((XALUOp_E == OP_DIV || XALUOp_E == OP_DIVU) && B == 32'd0) begin
            res_hi = A;
            res_lo = 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        Start = (XALUOp_E >= OP_MULT) && (XALUOp_E <= OP_DIVU) && (state_q == IDLE) && !cancel;
        Busy  = Start || (state_q == RUN);
        case (XALUOp_E)
            OP_MFHI: XALUOut = hi_q;
            OP_MFLO: XALUOut = lo_q;
            default: XALUOut = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        if (state_q == IDLE) begin
            if (Start) begin
                hi_n_d  = res_hi;
                lo_n_d  = res_lo;
                cnt_d   = (XALUOp_E <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                state_d = RUN;
            end else if (XALUOp_E == OP_MTHI && !cancel) begin
                hi_d = A;
            end else if (XALUOp_E == OP_MTLO && !cancel) begin
                lo_d = A;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                hi_d    = hi_n_q;
                lo_d    = lo_n_q;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_xalu.sv
// tb/tb_xalu.sv - scoreboard bench for xalu
module tb_xalu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cancel = 1'b0;
    logic [3:0]  xalu_op = 4'd0;
    logic [31:0] a_in = 32'd0, b_in = 32'd0;
    logic        start, busy;
    logic [31:0] hi, lo, xalu_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    xalu dut (
        .clk     (clk),
        .reset   (reset),
`ifdef XALU_CANCEL_EN
        .Cancel  (cancel),
`endif
        .XALUOp_E(xalu_op),
        .A       (a_in),
        .B       (b_in),
        .Start   (start),
        .Busy    (busy),
        .HI      (hi),
        .LO      (lo),
        .XALUOut (xalu_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [31:0] q, r;
        case (op)
            4'd1: begin ps = $signed(a) * $signed(b); return ps; end
            4'd2: return {32'd0, a} * {32'd0, b};
            4'd3: begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    // Issues one multi-cycle op, counts Busy cycles, checks HI/LO hold, then pops the scoreboard.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit poke);
        sb_t e;
        logic [31:0] old_hi, old_lo;
        int cnt, n;
        n = (op <= 4'd2) ? 5 : 10;
        @(negedge clk);
        old_hi = hi;
        old_lo = lo;
        xalu_op = op; a_in = a; b_in = b;
        e.hi = exp_hi; e.lo = exp_lo;
        sb.push_back(e);
        #1 check("start", {31'd0, start}, 32'd1);
        @(negedge clk);
        xalu_op = 4'd0; a_in = $urandom; b_in = $urandom;
        cnt = 1;
        while (busy && cnt < 200) begin
            cnt++;
            if (poke && cnt == 3) begin
                xalu_op = 4'd1;
                #1 check("start_in_run", {31'd0, start}, 32'd0);
            end
            check("hold_hi", hi, old_hi);
            check("hold_lo", lo, old_lo);
            @(negedge clk);
            xalu_op = 4'd0;
        end
        check("busy_cycles", 32'(cnt), 32'(n + 1));
        e = sb.pop_front();
        check("commit_hi", hi, e.hi);
        check("commit_lo", lo, e.lo);
    endtask

    task automatic single(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        xalu_op = op; a_in = a;
        @(negedge clk);
        xalu_op = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] m;
        logic [3:0]  op;
        logic [31:0] ra, rb;

        repeat (2) @(negedge clk);
        xalu_op = 4'd7;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_out", xalu_out, 32'd0);
        reset = 1'b1;
        xalu_op = 4'd0;

        // Async reset in the middle of a div discards it and clears HI/LO.
        single(4'd5, 32'd55);
        single(4'd6, 32'd66);
        @(negedge clk);
        xalu_op = 4'd3; a_in = 32'd100; b_in = 32'd7;
        @(negedge clk);
        xalu_op = 4'd0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrun_rst_busy", {31'd0, busy}, 32'd0);
        check("midrun_rst_hi", hi, 32'd0);
        check("midrun_rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        run_op(4'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        run_op(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(4'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        run_op(4'd4, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b0);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op = 4'(1 + (i % 4));
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0 || rb == 32'hFFFF_FFFF) rb = 32'd3;
            m = model(op, ra, rb);
            run_op(op, ra, rb, m[63:32], m[31:0], 1'b0);
        end

        // mthi/mtlo and mfhi/mflo paths.
        single(4'd5, 32'd1234);
        single(4'd6, 32'd4321);
        @(negedge clk);
        xalu_op = 4'd7;
        #1 check("mfhi", xalu_out, 32'd1234);
        xalu_op = 4'd8;
        #1 check("mflo", xalu_out, 32'd4321);
        xalu_op = 4'd9;
        #1 check("op9_out", xalu_out, 32'd0);
        check("op9_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("op9_hi", hi, 32'd1234);
        check("op9_lo", lo, 32'd4321);
        xalu_op = 4'd0;

`ifdef XALU_CANCEL_EN
        @(negedge clk);
        cancel = 1'b1;
        xalu_op = 4'd1; a_in = 32'd3; b_in = 32'd3;
        #1;
        check("cancel_start", {31'd0, start}, 32'd0);
        check("cancel_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        xalu_op = 4'd5; a_in = 32'd777;
        @(negedge clk);
        check("cancel_hi", hi, 32'd1234);
        check("cancel_lo", lo, 32'd4321);
        xalu_op = 4'd0;
        cancel = 1'b0;
        @(negedge clk);
        xalu_op = 4'd2; a_in = 32'd6; b_in = 32'd7;
        @(negedge clk);
        xalu_op = 4'd0;
        cancel = 1'b1;
        repeat (8) @(negedge clk);
        cancel = 1'b0;
        check("cancel_run_busy", {31'd0, busy}, 32'd0);
        check("cancel_run_hi", hi, 32'd0);
        check("cancel_run_lo", lo, 32'd42);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
